// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM key sequencer front-end.
package atm_pkg;

  localparam int AMOUNT_W  = 10;
  localparam int ACC_W     = 4;
  localparam int ACC_COUNT = 15;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CANCEL = 4'd11;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    BALANCE  = 2'd1,
    WITHDRAW = 2'd2,
    TRANSFER = 2'd3
  } select_t;

  typedef enum logic [1:0] {
    RES_NONE     = 2'd0,
    RES_WD_INSUF = 2'd1,
    RES_TR_INSUF = 2'd2,
    RES_SUCCESS  = 2'd3
  } result_t;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_INSUFFICIENT = 3'd1,
    ST_BAD_FIELD    = 3'd2,
    ST_OVERFLOW     = 3'd3,
    ST_CANCELLED    = 3'd4,
    ST_TIMEOUT      = 3'd5,
    ST_SAME_ACCOUNT = 3'd6
  } status_t;

endpackage

// File: rtl/atm_decimal_accum.sv
// Decimal digit accumulator with limit check; the wide intermediate keeps
// acc*10 + digit from wrapping before it is compared against the limit.
module atm_decimal_accum
  import atm_pkg::*;
#(
  parameter int VAL_W = AMOUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_strobe,
  input  logic [3:0]       digit,
  input  logic [VAL_W-1:0] limit,
  output logic [VAL_W-1:0] value,
  output logic             has_digit,
  output logic             over_limit
);

  localparam int WIDE_W = VAL_W + 4;

  logic [WIDE_W-1:0] nxt;

  assign nxt        = WIDE_W'(value) * WIDE_W'(10) + WIDE_W'(digit);
  assign over_limit = digit_strobe && (nxt > WIDE_W'(limit));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value     <= '0;
      has_digit <= 1'b0;
    end else if (digit_strobe && !over_limit) begin
      value     <= nxt[VAL_W-1:0];
      has_digit <= 1'b1;
    end
  end

endmodule

// File: rtl/atm_key_sequencer.sv
// Keypad-driven transaction sequencer: parses fields, issues one request to
// the ATM core, waits for its result or a timeout, and reports a status.
module atm_key_sequencer
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ACC_COUNT      = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [1:0]          req_select,
  output logic [ACC_W-1:0]    req_origin,
  output logic [ACC_W-1:0]    req_purpose,
  output logic [AMOUNT_W-1:0] req_amount,
  input  logic                rsp_valid,
  input  logic [1:0]          rsp_result,
  output logic                done,
  output logic [2:0]          status,
  output logic                busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {SEL, ORIGIN, PURPOSE, AMOUNT, ISSUE, WAIT, REPORT} state_t;

  state_t                state;
  select_t               sel_q;
  status_t               status_q;
  logic [ACC_W-1:0]      origin_q, purpose_q;
  logic [AMOUNT_W-1:0]   amount_q;
  logic [TMO_W-1:0]      tmo_cnt;

  logic                  entry, key_fire, is_digit, acc_clear;
  logic [AMOUNT_W-1:0]   acc_val, acc_limit;
  logic                  acc_has, acc_over;
  logic                  fin;
  status_t               fin_code;

  assign entry     = (state == SEL) || (state == ORIGIN) || (state == PURPOSE) || (state == AMOUNT);
  assign key_ready = entry;
  assign key_fire  = key_valid && key_ready;
  assign is_digit  = key_code <= 4'd9;
  assign acc_clear = (key_fire && (key_code == KEY_ENTER || key_code == KEY_CANCEL)) || acc_over;

  assign req_valid   = (state == ISSUE);
  assign req_select  = sel_q;
  assign req_origin  = origin_q;
  assign req_purpose = purpose_q;
  assign req_amount  = amount_q;
  assign status      = status_q;
  assign busy        = !((state == SEL) && !acc_has);

  always_comb begin
    acc_limit = '1;
    case (state)
      SEL:             acc_limit = AMOUNT_W'(3);
      ORIGIN, PURPOSE: acc_limit = AMOUNT_W'(ACC_COUNT - 1);
      default:         acc_limit = '1;
    endcase
  end

  atm_decimal_accum #(.VAL_W(AMOUNT_W)) u_accum (
    .clk          (clk),
    .rst          (rst),
    .clear        (acc_clear),
    .digit_strobe (key_fire && is_digit),
    .digit        (key_code),
    .limit        (acc_limit),
    .value        (acc_val),
    .has_digit    (acc_has),
    .over_limit   (acc_over)
  );

  // Early-termination outcome of the key accepted this cycle, if any.
  always_comb begin
    fin      = 1'b0;
    fin_code = ST_OK;
    if (key_fire) begin
      if (key_code == KEY_CANCEL) begin
        fin      = 1'b1;
        fin_code = ST_CANCELLED;
      end else if (acc_over) begin
        fin      = 1'b1;
        fin_code = (state == AMOUNT) ? ST_OVERFLOW : ST_BAD_FIELD;
      end else if (key_code == KEY_ENTER) begin
        if (!acc_has) begin
          fin      = 1'b1;
          fin_code = ST_BAD_FIELD;
        end else if ((state == PURPOSE) && (acc_val[ACC_W-1:0] == origin_q)) begin
          fin      = 1'b1;
          fin_code = ST_SAME_ACCOUNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEL;
      sel_q     <= NOP;
      origin_q  <= '0;
      purpose_q <= '0;
      amount_q  <= '0;
      tmo_cnt   <= '0;
      done      <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      done <= 1'b0;
      case (state)
        SEL, ORIGIN, PURPOSE, AMOUNT: begin
          if (fin) begin
            state    <= REPORT;
            done     <= 1'b1;
            status_q <= fin_code;
          end else if (key_fire && key_code == KEY_ENTER) begin
            case (state)
              SEL: begin
                sel_q <= select_t'(acc_val[1:0]);
                state <= (acc_val == '0) ? ISSUE : ORIGIN;
              end
              ORIGIN: begin
                origin_q <= acc_val[ACC_W-1:0];
                case (sel_q)
                  BALANCE:  state <= ISSUE;
                  WITHDRAW: state <= AMOUNT;
                  default:  state <= PURPOSE;
                endcase
              end
              PURPOSE: begin
                purpose_q <= acc_val[ACC_W-1:0];
                state     <= AMOUNT;
              end
              default: begin
                amount_q <= acc_val;
                state    <= ISSUE;
              end
            endcase
          end
        end
        ISSUE: begin
          if (req_ready) begin
            state   <= WAIT;
            tmo_cnt <= '0;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            state <= REPORT;
            done  <= 1'b1;
            case (result_t'(rsp_result))
              RES_WD_INSUF, RES_TR_INSUF: status_q <= ST_INSUFFICIENT;
              default:                    status_q <= ST_OK;
            endcase
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
            state    <= REPORT;
            done     <= 1'b1;
            status_q <= ST_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state     <= SEL;
          sel_q     <= NOP;
          origin_q  <= '0;
          purpose_q <= '0;
          amount_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_key_sequencer.sv
// Directed bench for atm_key_sequencer with a short timeout (8 cycles).
module tb_atm_key_sequencer;

  localparam logic [3:0] ENT = 4'd10;
  localparam logic [3:0] CAN = 4'd11;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_select;
  logic [3:0] req_origin;
  logic [3:0] req_purpose;
  logic [9:0] req_amount;
  logic       rsp_valid;
  logic [1:0] rsp_result;
  logic       done;
  logic [2:0] status;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  atm_key_sequencer #(.TIMEOUT_CYCLES(8), .ACC_COUNT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_select  (req_select),
    .req_origin  (req_origin),
    .req_purpose (req_purpose),
    .req_amount  (req_amount),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .done        (done),
    .status      (status),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic respond(input logic [1:0] r);
    rsp_valid  = 1'b1;
    rsp_result = r;
    tick();
    rsp_valid  = 1'b0;
    rsp_result = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_code = '0; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_result = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({key_ready, req_valid, done, busy, status} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_ctrl: got kr/rv/done/busy/status=%b%b%b%b/%0d expected 1000/0",
               key_ready, req_valid, done, busy, status);
    end
    n_cmp++;
    if ({req_select, req_origin, req_purpose, req_amount} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_fields: got %h expected 00000", {req_select, req_origin, req_purpose, req_amount});
    end
  endtask

  task automatic test_transfer();
    key(3); key(ENT); key(2); key(ENT); key(7); key(ENT); key(5); key(0); key(ENT);
    n_cmp++;
    if ({req_valid, req_select, req_origin, req_purpose, req_amount} !== {1'b1, 2'd3, 4'd2, 4'd7, 10'd50}) begin
      n_err++;
      $display("FAIL xfer_req: got v=%b sel=%0d org=%0d pur=%0d amt=%0d expected v=1 sel=3 org=2 pur=7 amt=50",
               req_valid, req_select, req_origin, req_purpose, req_amount);
    end
    tick();
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++; $display("FAIL xfer_req_one_cycle: got req_valid=%b expected 0", req_valid);
    end
    respond(2'd3);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL xfer_done: got done=%b status=%0d expected done=1 status=0", done, status);
    end
    tick();
    n_cmp++;
    if ({done, key_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL xfer_after: got done/kr/busy=%b%b%b expected 010", done, key_ready, busy);
    end
  endtask

  task automatic test_withdraw_insufficient();
    key(12);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL ignored_key: got busy/done=%b%b expected 00", busy, done);
    end
    key(2); key(ENT); key(4); key(13); key(ENT); key(9); key(0); key(0); key(ENT);
    n_cmp++;
    if ({req_valid, req_select, req_origin, req_purpose, req_amount} !== {1'b1, 2'd2, 4'd4, 4'd0, 10'd900}) begin
      n_err++;
      $display("FAIL wd_req: got v=%b sel=%0d org=%0d pur=%0d amt=%0d expected v=1 sel=2 org=4 pur=0 amt=900",
               req_valid, req_select, req_origin, req_purpose, req_amount);
    end
    tick();
    respond(2'd1);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL wd_insuf: got done=%b status=%0d expected done=1 status=1", done, status);
    end
    tick();
  endtask

  task automatic test_nop();
    key(0); key(ENT);
    n_cmp++;
    if ({req_valid, req_select, req_origin, req_amount} !== {1'b1, 2'd0, 4'd0, 10'd0}) begin
      n_err++; $display("FAIL nop_req: got v=%b sel=%0d expected v=1 sel=0", req_valid, req_select);
    end
    tick();
    respond(2'd0);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL nop_done: got done=%b status=%0d expected done=1 status=0", done, status);
    end
    tick();
  endtask

  task automatic test_range_errors();
    key(2); key(ENT); key(1); key(ENT); key(1); key(0); key(2);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL amt_1023_ok: got done=%b expected 0", done);
    end
    key(4);
    n_cmp++;
    if ({done, status, req_valid} !== {1'b1, 3'd3, 1'b0}) begin
      n_err++; $display("FAIL amt_overflow: got done=%b status=%0d rv=%b expected 1/3/0", done, status, req_valid);
    end
    tick();
    key(1); key(ENT); key(1); key(4);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL acct_14_ok: got done=%b expected 0", done);
    end
    key(CAN); tick();
    key(1); key(ENT); key(1); key(5);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd2}) begin
      n_err++; $display("FAIL acct_15_bad: got done=%b status=%0d expected 1/2", done, status);
    end
    tick();
    key(4);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd2}) begin
      n_err++; $display("FAIL sel_4_bad: got done=%b status=%0d expected 1/2", done, status);
    end
    tick();
    key(ENT);
    n_cmp++;
    if ({done, status, req_valid} !== {1'b1, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL empty_enter: got done=%b status=%0d rv=%b expected 1/2/0", done, status, req_valid);
    end
    tick();
  endtask

  task automatic test_same_and_cancel();
    key(3); key(ENT); key(6); key(ENT); key(6); key(ENT);
    n_cmp++;
    if ({done, status, req_valid} !== {1'b1, 3'd6, 1'b0}) begin
      n_err++; $display("FAIL same_acct: got done=%b status=%0d rv=%b expected 1/6/0", done, status, req_valid);
    end
    tick();
    key(2); key(ENT); key(3); key(ENT); key(5); key(CAN);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd4}) begin
      n_err++; $display("FAIL cancel: got done=%b status=%0d expected 1/4", done, status);
    end
    tick();
    n_cmp++;
    if ({key_ready, busy, req_select, req_origin, req_amount} !== {1'b1, 1'b0, 2'd0, 4'd0, 10'd0}) begin
      n_err++; $display("FAIL cancel_clean: got kr=%b busy=%b sel=%0d org=%0d amt=%0d expected 1/0/0/0/0",
                        key_ready, busy, req_select, req_origin, req_amount);
    end
    key(1); key(ENT); key(5); key(ENT);
    n_cmp++;
    if ({req_valid, req_select, req_origin, req_purpose, req_amount} !== {1'b1, 2'd1, 4'd5, 4'd0, 10'd0}) begin
      n_err++; $display("FAIL after_cancel_req: got v=%b sel=%0d org=%0d pur=%0d amt=%0d expected 1/1/5/0/0",
                        req_valid, req_select, req_origin, req_purpose, req_amount);
    end
    tick(); respond(2'd3); tick();
  endtask

  task automatic test_stall_timeout();
    int unsigned n;
    req_ready = 1'b0;
    key(3); key(ENT); key(1); key(ENT); key(2); key(ENT); key(7); key(ENT);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({req_valid, req_select, req_origin, req_purpose, req_amount} !== {1'b1, 2'd3, 4'd1, 4'd2, 10'd7}) begin
        n_err++; $display("FAIL stall_stable[%0d]: got v=%b sel=%0d org=%0d pur=%0d amt=%0d expected 1/3/1/2/7",
                          i, req_valid, req_select, req_origin, req_purpose, req_amount);
      end
      tick();
    end
    req_ready = 1'b1;
    tick();
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd5} || n != 9) begin
      n_err++; $display("FAIL timeout: got done=%b status=%0d after %0d cycles expected 1/5 after 9", done, status, n);
    end
    tick();
  endtask

  task automatic test_rsp_at_timeout();
    key(1); key(ENT); key(3); key(ENT);
    tick();
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL pre_timeout: got done=%b expected 0", done);
    end
    respond(2'd3);
    n_cmp++;
    if ({done, status} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL rsp_priority: got done=%b status=%0d expected 1/0", done, status);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    key(2); key(ENT); key(3); key(ENT); key(9); key(ENT);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({req_valid, key_ready, busy, done, status} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_wait: got rv/kr/busy/done=%b%b%b%b status=%0d expected 0100/0",
                        req_valid, key_ready, busy, done, status);
    end
    respond(2'd3);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL late_rsp: got done=%b expected 0", done);
    end
    tick();
    n_cmp++;
    if ({done, key_ready} !== 2'b01) begin
      n_err++; $display("FAIL late_rsp_after: got done/kr=%b%b expected 01", done, key_ready);
    end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_withdraw_insufficient();
    test_nop();
    test_range_errors();
    test_same_and_cancel();
    test_stall_timeout();
    test_rsp_at_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/atm_key_sequencer.md
# atm_key_sequencer

Upstream command front-end for the ATM transaction core. Accepts keypad codes over a valid/ready handshake, parses them into a complete transaction (operation select, origin account, purpose account, amount), and validates field ranges. It then issues one request to the core and waits for the core's 2-bit result. It reports a final status to the display/host side.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles to wait in `WAIT` for a core response before abandoning the request.
- `ACC_COUNT`, default 15: number of valid accounts; valid IDs are 0..`ACC_COUNT`-1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  a keypad code is presented.
- `key_code`  in  4  0–9 are digits; 10 is ENTER; 11 is CANCEL; 12–15 are ignored (accepted, no effect).
- `key_ready`  out  1  sequencer can accept a key.
- `req_valid`  out  1  transaction request to the core is valid.
- `req_ready`  in  1  core accepts the request.
- `req_select`  out  2  operation: 0 NOP, 1 BALANCE, 2 WITHDRAW, 3 TRANSFER.
- `req_origin`  out  4  origin account.
- `req_purpose`  out  4  purpose account; 0 unless the operation is TRANSFER.
- `req_amount`  out  10  amount; 0 unless the operation is WITHDRAW or TRANSFER.
- `rsp_valid`  in  1  core result is valid.
- `rsp_result`  in  2  core result: 0 none, 1 withdraw insufficient, 2 transfer insufficient, 3 success.
- `done`  out  1  one-cycle pulse when a transaction ends.
- `status`  out  3  final status, updated with `done`: 0 OK, 1 INSUFFICIENT, 2 BAD_FIELD, 3 OVERFLOW, 4 CANCELLED, 5 TIMEOUT, 6 SAME_ACCOUNT.
- `busy`  out  1  high in every state except `SEL` with an empty accumulator.

## Operation
- States: `SEL`, `ORIGIN`, `PURPOSE`, `AMOUNT`, `ISSUE`, `WAIT`, `REPORT`.
- A key is consumed when `key_valid` and `key_ready` are both high. `key_ready` is 1 in `SEL`, `ORIGIN`, `PURPOSE` and `AMOUNT`, and 0 in all other states.
- Each field is entered as decimal digits terminated by ENTER.
  - Each digit updates the accumulator: acc = acc*10 + digit.
  - Leading zeros are allowed.
  - ENTER with no digits entered gives BAD_FIELD.
- Field limits:
  - select: at most 3.
  - accounts: at most `ACC_COUNT`-1.
  - amount: at most 1023.
- A digit that pushes the accumulator past the field limit ends the transaction immediately (`REPORT`):
  - OVERFLOW for the amount field;
  - BAD_FIELD for the select and account fields.
- Field routing after ENTER:
  - `SEL`: select 0 goes to `ISSUE`; 1–3 go to `ORIGIN`.
  - `ORIGIN`: select 1 goes to `ISSUE`; 2 goes to `AMOUNT`; 3 goes to `PURPOSE`.
  - `PURPOSE`: if purpose equals origin, go to `REPORT` with SAME_ACCOUNT; otherwise go to `AMOUNT`.
  - `AMOUNT`: go to `ISSUE`.
- CANCEL in any entry state: go to `REPORT` with CANCELLED. The accumulator and all fields are cleared.
- `ISSUE`: `req_valid`=1 with all `req_*` fields held stable until `req_ready` is sampled high, then go to `WAIT`.
- `WAIT`:
  - On `rsp_valid`, map the result: 3 or 0 gives OK; 1 or 2 gives INSUFFICIENT. Then go to `REPORT`.
  - `rsp_valid` outside `WAIT` is ignored.
- `REPORT`: `done`=1 for exactly one cycle, `status` is latched, then go to `SEL` with fields cleared. `status` holds until the next `done`.

## Timing
- Reset values: state `SEL`; `key_ready`=1; `req_valid`=0; all `req_*` fields 0; `done`=0; `status`=0; `busy`=0; timeout counter 0.
- Reset in any state, including `ISSUE` or `WAIT`, takes effect on the next edge. An outstanding `req_valid` drops and any pending response is discarded.
- ENTER on the final field: `req_valid` rises on the next cycle.
- Handshake completes in the cycle where `req_valid` and `req_ready` are both high; `WAIT` starts on the following cycle. With `req_ready` tied high, `req_valid` is high for exactly one cycle.
- `rsp_valid` sampled in `WAIT`: `done` is high on the next cycle.
- Timeout:
  - The counter clears on entry to `WAIT` and increments each `WAIT` cycle without `rsp_valid`.
  - When the count reaches `TIMEOUT_CYCLES`, go to `REPORT` with TIMEOUT.
  - `rsp_valid` in that same cycle takes priority over the timeout.
- Error digit, CANCEL, or SAME_ACCOUNT: `done` on the cycle after the key is accepted. No request is issued.
- Throughput: one transaction in flight. The first key of the next transaction is accepted the cycle after `done`.
- Arithmetic: use a 14-bit accumulator intermediate, so acc*10 + 9 never wraps before the limit compare.

## Structure
- `atm_pkg` holds:
  - key code constants (`KEY_ENTER`, `KEY_CANCEL`);
  - the select enum (NOP, BALANCE, WITHDRAW, TRANSFER);
  - the core result codes;
  - the status enum;
  - `AMOUNT_W`=10, `ACC_W`=4, `ACC_COUNT`=15.
- Sub-module `atm_decimal_accum`: inputs are clear, digit strobe, digit value and limit; outputs are value, `has_digit` and `over_limit`. The FSM and handshake logic stay in `atm_key_sequencer`.

## Test plan
- Transfer: keys 3,ENTER,2,ENTER,7,ENTER,5,0,ENTER with `req_ready`=1 → one-cycle `req_valid` with select=3, origin=2, purpose=7, amount=50. Then `rsp_result`=3 → `done` with status 0.
- Withdraw, insufficient funds: keys 2,ENTER,4,ENTER,9,0,0,ENTER; then `rsp_result`=1 → status 1. `req_purpose` must be 0.
- Range errors:
  - Amount keys 1,0,2,4 → OVERFLOW on the digit 4; no request issued.
  - Account key 1,5 → BAD_FIELD.
  - ENTER with no digits → BAD_FIELD.
- SAME_ACCOUNT and CANCEL:
  - Transfer with origin 6 and purpose 6 → status 6.
  - CANCEL mid-amount → status 4; next transaction starts clean.
- Handshake stall and timeout:
  - Hold `req_ready`=0 for 5 cycles → `req_*` fields stay stable.
  - With `TIMEOUT_CYCLES`=8 and no response → status 5.
  - `rsp_valid` in the timeout cycle itself → OK.
- Reset during `WAIT`: `req_valid`=0 and state `SEL` next cycle. A late `rsp_valid` afterwards produces no `done`.
